// File: rtl/simple_processor_pkg.sv
// Shared types and constants for the simple processor front end.
// Holds the fetch FSM encoding and the instruction buffer entry layout.
package simple_processor_pkg;

  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned PC_STEP    = 2;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry shift FIFO for fetched instructions; the head always sits in e0_q
// so the downstream outputs come straight from registers. Flush wins over push/pop.
import simple_processor_pkg::*;

module fetch_buffer #(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk_i,
  input  logic       arst_ni,
  input  logic       push_i,
  input  entry_t     entry_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output entry_t     head_o,
  output logic       head_valid_o,
  output logic [1:0] count_next_o
);

  entry_t e0_q, e1_q;
  logic   v0_q, v1_q;
  logic   pop_eff;
  logic [1:0] count;

  // Popping an empty buffer is a no-op; v1_q is only ever set while v0_q is.
  assign pop_eff = pop_i & v0_q;
  assign count   = 2'(v0_q) + 2'(v1_q);

  always_comb begin
    count_next_o = count;
    if (flush_i) begin
      count_next_o = 2'd0;
    end else begin
      count_next_o = count + 2'(push_i) - 2'(pop_eff);
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      e0_q <= '0;
      e1_q <= '0;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else if (flush_i) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      case ({push_i, pop_eff})
        2'b11: begin
          if (v1_q) begin
            e0_q <= e1_q;
            e1_q <= entry_i;
          end else begin
            e0_q <= entry_i;
          end
        end
        2'b01: begin
          e0_q <= e1_q;
          v0_q <= v1_q;
          v1_q <= 1'b0;
        end
        2'b10: begin
          if (!v0_q) begin
            e0_q <= entry_i;
            v0_q <= 1'b1;
          end else begin
            e1_q <= entry_i;
            v1_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_o       = e0_q;
  assign head_valid_o = v0_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction memory port,
// buffers up to two responses and handles redirects by flushing in-flight work.
import simple_processor_pkg::*;

module instr_fetch_unit #(
  parameter int unsigned MEM_ADDR_WIDTH = ADDR_WIDTH,
  parameter int unsigned MEM_DATA_WIDTH = DATA_WIDTH,
  parameter int unsigned PC_STEP        = simple_processor_pkg::PC_STEP
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic [MEM_ADDR_WIDTH-1:0] boot_addr_i,
  output logic                      imem_req_o,
  output logic [MEM_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [MEM_DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                      imem_ack_i,
  input  logic                      redirect_i,
  input  logic [MEM_ADDR_WIDTH-1:0] redirect_addr_i,
  output logic                      instr_valid_o,
  output logic [MEM_DATA_WIDTH-1:0] instr_o,
  output logic [MEM_ADDR_WIDTH-1:0] instr_pc_o,
  input  logic                      instr_ready_i,
  output fetch_state_e              dbg_state_o
);

  typedef struct packed {
    logic [MEM_DATA_WIDTH-1:0] instr;
    logic [MEM_ADDR_WIDTH-1:0] pc;
  } entry_t;

  // Handshakes: the memory side completes a request in any cycle where
  // imem_req_o and imem_ack_i are both high (request held stable until then);
  // decode consumes the head in any cycle where instr_valid_o and instr_ready_i are both high.

  fetch_state_e              state_q;
  logic                      req_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [MEM_ADDR_WIDTH-1:0] target_q;

  logic       ack_acc;
  logic       buf_push;
  logic       buf_pop;
  logic       buf_flush;
  logic [1:0] buf_count_next;
  entry_t     buf_entry;
  entry_t     buf_head;

  assign ack_acc   = req_q & imem_ack_i;
  assign buf_push  = (state_q == RUN) & ack_acc & ~redirect_i;
  assign buf_pop   = instr_valid_o & instr_ready_i;
  // DROP keeps the buffer empty; a stale response must never become visible.
  assign buf_flush = ((state_q == RUN) & redirect_i) | (state_q == DROP);
  assign buf_entry = '{instr: imem_rdata_i, pc: addr_q};

  fetch_buffer #(
    .entry_t (entry_t)
  ) u_fetch_buffer (
    .clk_i        (clk_i),
    .arst_ni      (arst_ni),
    .push_i       (buf_push),
    .entry_i      (buf_entry),
    .pop_i        (buf_pop),
    .flush_i      (buf_flush),
    .head_o       (buf_head),
    .head_valid_o (instr_valid_o),
    .count_next_o (buf_count_next)
  );

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= BOOT;
      req_q    <= 1'b0;
      addr_q   <= '0;
      target_q <= '0;
    end else begin
      case (state_q)
        BOOT: begin
          addr_q  <= boot_addr_i;
          req_q   <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          if (redirect_i) begin
            if (ack_acc || !req_q) begin
              addr_q <= redirect_addr_i;
              req_q  <= (buf_count_next < 2'd2);
            end else begin
              // An un-acked request cannot be withdrawn; wait for it to drain.
              target_q <= redirect_addr_i;
              state_q  <= DROP;
            end
          end else begin
            if (ack_acc) begin
              addr_q <= addr_q + MEM_ADDR_WIDTH'(PC_STEP);
            end
            req_q <= (buf_count_next < 2'd2);
          end
        end
        DROP: begin
          if (ack_acc) begin
            addr_q  <= redirect_i ? redirect_addr_i : target_q;
            req_q   <= 1'b1;
            state_q <= RUN;
          end else if (redirect_i) begin
            target_q <= redirect_addr_i;
          end
        end
        default: begin
          state_q <= BOOT;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign instr_o     = buf_head.instr;
  assign instr_pc_o  = buf_head.pc;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a behavioural memory plus a fetch-stream
// model (expected PC, stale-response flag, queue of deliverable instructions).
import simple_processor_pkg::*;

module tb_instr_fetch_unit;

  localparam int A = 16;
  localparam int D = 16;
  localparam int W = A + D;

  // ---------------- clock / reset ----------------
  logic         clk_i = 1'b0;
  logic         arst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [A-1:0] boot_addr_i = '0;
  logic         imem_req_o;
  logic [A-1:0] imem_addr_o;
  logic [D-1:0] imem_rdata_i = '0;
  logic         imem_ack_i = 1'b0;
  logic         redirect_i = 1'b0;
  logic [A-1:0] redirect_addr_i = '0;
  logic         instr_valid_o;
  logic [D-1:0] instr_o;
  logic [A-1:0] instr_pc_o;
  logic         instr_ready_i = 1'b0;
  fetch_state_e dbg_state_o;

  instr_fetch_unit dut (
    .clk_i           (clk_i),
    .arst_ni         (arst_ni),
    .boot_addr_i     (boot_addr_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_rdata_i    (imem_rdata_i),
    .imem_ack_i      (imem_ack_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .instr_valid_o   (instr_valid_o),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .instr_ready_i   (instr_ready_i),
    .dbg_state_o     (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [A-1:0] model_pc;
  bit           stale;
  logic [A-1:0] stale_target;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [D-1:0] mem_word(input logic [A-1:0] a);
    logic [31:0] p;
    p = a * 32'h9E37 ^ 32'h5A5A;
    return p[D-1:0];
  endfunction

  // ---------------- stimulus knobs ----------------
  int           ready_pct = 100;
  int           dmin = 0;
  int           dmax = 0;
  int           redir_permil = 0;
  bit           spur_en = 1'b0;
  bit           force_redir = 1'b0;
  logic [A-1:0] force_addr = '0;
  bit           busy = 1'b0;
  int           wait_cnt = 0;

  // ---------------- driver ----------------
  task automatic apply_reset(input logic [A-1:0] boot);
    arst_ni = 1'b0;
    imem_ack_i = 1'b0;
    redirect_i = 1'b0;
    instr_ready_i = 1'b0;
    boot_addr_i = boot;
    repeat (2) @(negedge clk_i);
    check("rst_req", W'(imem_req_o), W'(0));
    check("rst_addr", W'(imem_addr_o), W'(0));
    check("rst_valid", W'(instr_valid_o), W'(0));
    check("rst_instr", W'(instr_o), W'(0));
    check("rst_pc", W'(instr_pc_o), W'(0));
    check("rst_state", W'(dbg_state_o), W'(BOOT));
    exp_q.delete();
    model_pc = boot;
    stale = 1'b0;
    busy = 1'b0;
    // A redirect during the boot cycle must have no effect.
    redirect_i = 1'b1;
    redirect_addr_i = 16'h0400;
    arst_ni = 1'b1;
  endtask

  task automatic cycle();
    bit redir;
    bit acc;
    logic [A-1:0] tgt;
    @(negedge clk_i);
    check("valid", W'(instr_valid_o), W'(exp_q.size() != 0));
    check("req", W'(imem_req_o), W'(exp_q.size() < 2));
    check("addr", W'(imem_addr_o), W'(model_pc));
    if (exp_q.size() != 0) check("head", {instr_o, instr_pc_o}, exp_q[0]);

    instr_ready_i = ($urandom_range(0, 99) < ready_pct);
    if (!imem_req_o) begin
      busy = 1'b0;
      imem_ack_i = spur_en && ($urandom_range(0, 3) == 0);
    end else begin
      if (!busy) begin
        busy = 1'b1;
        wait_cnt = $urandom_range(dmin, dmax);
      end
      if (wait_cnt == 0) begin
        imem_ack_i = 1'b1;
        busy = 1'b0;
      end else begin
        wait_cnt--;
        imem_ack_i = 1'b0;
      end
    end
    imem_rdata_i = (imem_ack_i && imem_req_o) ? mem_word(imem_addr_o) : D'($urandom);

    redir = force_redir || ($urandom_range(0, 999) < redir_permil);
    tgt = force_redir ? force_addr : (A'($urandom) & ~A'(1));
    force_redir = 1'b0;
    redirect_i = redir;
    redirect_addr_i = redir ? tgt : A'($urandom);

    acc = imem_req_o && imem_ack_i;
    if (redir) begin
      exp_q.delete();
      if (acc || !imem_req_o) begin
        model_pc = tgt;
        stale = 1'b0;
      end else begin
        stale = 1'b1;
        stale_target = tgt;
      end
    end else begin
      if (instr_valid_o && instr_ready_i && exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc) begin
        if (stale) begin
          model_pc = stale_target;
          stale = 1'b0;
        end else begin
          exp_q.push_back({mem_word(model_pc), model_pc});
          model_pc = model_pc + A'(2);
        end
      end
    end
  endtask

  task automatic redir_cycle(input logic [A-1:0] a);
    force_redir = 1'b1;
    force_addr = a;
    cycle();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Boot: same-cycle ack, decode always ready.
    apply_reset(16'h0100);
    ready_pct = 100; dmin = 0; dmax = 0;
    repeat (12) cycle();

    // Backpressure: decode stalls for 6 cycles, then drains.
    ready_pct = 0;
    repeat (6) cycle();
    ready_pct = 100;
    repeat (8) cycle();

    // Slow memory: every ack delayed by 3 cycles.
    dmin = 3; dmax = 3;
    repeat (16) cycle();

    // Redirect with a full buffer, then with a pending request, then in DROP.
    dmin = 0; dmax = 0; ready_pct = 0;
    repeat (4) cycle();
    dmin = 3; dmax = 3; ready_pct = 100;
    redir_cycle(16'h0200);
    redir_cycle(16'h0300);
    redir_cycle(16'h0340);
    repeat (8) cycle();
    // Redirect coinciding with a same-cycle ack.
    dmin = 0; dmax = 0;
    redir_cycle(16'h0200);
    repeat (6) cycle();

    // Random traffic including spurious acks while idle.
    dmin = 0; dmax = 3; ready_pct = 60; redir_permil = 60; spur_en = 1'b1;
    repeat (400) cycle();
    redir_permil = 0; spur_en = 1'b0;

    // Address wrap-around.
    apply_reset(16'hFFFE);
    ready_pct = 100; dmin = 0; dmax = 0;
    repeat (6) cycle();

    // Mid-operation reset with one buffered entry.
    apply_reset(16'h0800);
    ready_pct = 0; dmin = 0; dmax = 0;
    cycle();
    @(posedge clk_i);
    #2;
    check("pre_rst_valid", W'(instr_valid_o), W'(1));
    arst_ni = 1'b0;
    #1;
    check("arst_req", W'(imem_req_o), W'(0));
    check("arst_addr", W'(imem_addr_o), W'(0));
    check("arst_valid", W'(instr_valid_o), W'(0));
    check("arst_instr", W'(instr_o), W'(0));
    check("arst_pc", W'(instr_pc_o), W'(0));
    apply_reset(16'h0A00);
    ready_pct = 70; dmin = 0; dmax = 2;
    repeat (20) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the simple processor. It owns the program counter, issues requests on the instruction memory port, and holds returned instructions in a 2-entry buffer. It presents them to the downstream decode stage on a valid/ready handshake and supports a one-cycle redirect (branch/jump) that flushes in-flight and buffered instructions.

## Interface
- `MEM_ADDR_WIDTH`, default `simple_processor_pkg::ADDR_WIDTH`: width of the instruction address bus.
- `MEM_DATA_WIDTH`, default `simple_processor_pkg::DATA_WIDTH`: width of the instruction word.
- `PC_STEP`, default `simple_processor_pkg::PC_STEP` (2): PC increment per fetched instruction.

Ports:
- `clk_i`  in  1  global synchronous clock; single clock domain.
- `arst_ni`  in  1  asynchronous, active-low reset.
- `boot_addr_i`  in  MEM_ADDR_WIDTH  first fetch address after reset.
- `imem_req_o`  out  1  request active at `imem_addr_o`.
- `imem_addr_o`  out  MEM_ADDR_WIDTH  instruction address.
- `imem_rdata_i`  in  MEM_DATA_WIDTH  instruction data, valid with ack.
- `imem_ack_i`  in  1  request completed (1-cycle pulse).
- `redirect_i`  in  1  flush and restart fetch at `redirect_addr_i`.
- `redirect_addr_i`  in  MEM_ADDR_WIDTH  redirect target.
- `instr_valid_o`  out  1  `instr_o` / `instr_pc_o` hold a valid instruction.
- `instr_o`  out  MEM_DATA_WIDTH  instruction at the buffer head.
- `instr_pc_o`  out  MEM_ADDR_WIDTH  address of `instr_o`.
- `instr_ready_i`  in  1  decode accepts the head this cycle.

## Operation
- **FSM states:** BOOT, RUN, DROP. All state and outputs are registered.
- **Reset values:**
  - state = BOOT.
  - `imem_req_o`=0, `imem_addr_o`='0.
  - Buffer count=0, so `instr_valid_o`=0.
  - `instr_o`='0, `instr_pc_o`='0.
- **BOOT:**
  - On the first edge after reset release: `imem_addr_o`<=`boot_addr_i`, `imem_req_o`<=1, go to RUN.
  - `redirect_i` is ignored in BOOT.
- **Memory handshake:**
  - While `imem_req_o`=1 and `imem_ack_i`=0, `imem_addr_o` and `imem_req_o` are held stable.
  - Ack is accepted only while `imem_req_o`=1. Ack in the same cycle the request is raised is legal.
- **RUN, on ack without redirect:**
  - Push {`imem_rdata_i`, `imem_addr_o`} into the buffer.
  - `imem_addr_o`<=`imem_addr_o`+`PC_STEP`, computed modulo 2^MEM_ADDR_WIDTH (wraps to 0, no flag).
- **Request gating:** `imem_req_o` next = (count_next < 2) and not in BOOT.
  - A raised request therefore always has buffer space; ack never overflows the buffer.
- **Pop:** when `instr_valid_o` & `instr_ready_i`. Push and pop in the same cycle leaves count unchanged.
- **Redirect:**
  - `redirect_i`=1 in RUN flushes the buffer: count<=0 and any same-cycle pop is void.
  - With ack in the same cycle, or no request pending: response discarded, `imem_addr_o`<=`redirect_addr_i`, request re-evaluated per the gating rule, stay in RUN.
  - With a request pending and no ack: keep `imem_req_o`/`imem_addr_o`, latch the target, go to DROP.
- **DROP:**
  - Buffer stays empty and no pushes occur.
  - On ack: discard data, `imem_addr_o`<=latched target, `imem_req_o`<=1, go to RUN.
  - A further redirect in DROP overwrites the latched target.
- **Ordering:** instructions leave in fetch order. `instr_pc_o` always equals the address that fetched `instr_o`.

## Timing
- Fetch latency: ack at edge N, then `instr_valid_o`=1 after edge N (visible in cycle N+1) with the matching data.
- Throughput is one instruction per cycle when memory acks in the same cycle and decode is always ready.
- When decode stalls, at most 2 acks are absorbed. `imem_req_o` drops in the cycle after the buffer becomes full, and re-asserts in the cycle after the first pop.
- Redirect: `instr_valid_o`=0 in the cycle after `redirect_i`. The first request at the target appears one cycle after `redirect_i`, or one cycle after the draining ack in DROP.
- Reset assertion mid-operation immediately forces all reset values, asynchronously; any pending memory response is ignored.

## Structure
- `simple_processor_pkg` holds:
  - `ADDR_WIDTH`, `DATA_WIDTH`, `PC_STEP`.
  - `fetch_state_e` typedef (BOOT, RUN, DROP).
  - `fetch_entry_t` packed struct {instr, pc}.
- Sub-module `fetch_buffer`: 2-entry synchronous FIFO of `fetch_entry_t` with push, pop, flush and count, flush having priority. The PC/FSM logic stays in `instr_fetch_unit`.

## Test plan
- **Boot:** `boot_addr_i`=0x0100, memory acks every request in the same cycle, ready=1. Expect `imem_addr_o` 0x0100, 0x0102, 0x0104…; `instr_pc_o` matches one cycle later; one instruction per cycle.
- **Backpressure:** ready=0 for 6 cycles. Expect exactly 2 pushes, `imem_req_o`=0 with address held at the next PC. Then ready=1: the 2 instructions drain in order and fetch resumes, with no loss and no duplicates.
- **Slow memory:** ack delayed 3 cycles. Expect `imem_req_o` and `imem_addr_o` stable for all 4 cycles and a single push on ack.
- **Redirect variants:** redirect to 0x0200 while the buffer is full, then redirect with a pending un-acked request. Expect `instr_valid_o` low the next cycle and the stale response dropped. The first delivered `instr_pc_o` is 0x0200; in the pending case, redirect + ack in the same cycle is also covered.
- **Wrap-around:** `boot_addr_i`=max-1 (e.g. 0xFFFE for 16-bit). Expect the next request at 0x0000.
- **Mid-operation reset:** assert `arst_ni` low mid-stream with the buffer holding 1 entry. Expect all outputs at reset values immediately, and the boot sequence restarting after release.
